rr_decoder_arbiter: RTL and testbench

- Round-robin arbiter sharing one 2-to-4 decoder-driven resource among 4 requesters.
- Produces the decoder's 2-bit select and enable from registered state, plus a matching one-hot grant vector.
- Holds each grant until the owner signals done, drops its request, or (optionally) times out.
- Sits directly in front of the decoder; all outputs are registered.

---
 rtl/rr_decoder_arbiter_if.sv | 21 ++
 rtl/rr_decoder_arbiter.sv | 137 +++++++++++++
 tb/tb_rr_decoder_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/rr_decoder_arbiter_if.sv
// Bus between rr_decoder_arbiter and its requesters / downstream 2-to-4 decoder.
// The master side drives requests and done; the slave side is the arbiter.
interface rr_decoder_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic       en;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;

    modport master (
        output req, done,
        input  sel, en, grant, busy, timeout
    );

    modport slave (
        input  req, done,
        output sel, en, grant, busy, timeout
    );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter driving a 2-to-4 decoder select/enable for four requesters.
// Optional forced release after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_decoder_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_decoder_arbiter_if.slave bus
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
        $error("rr_decoder_arbiter: illegal MAX_HOLD/CNT_W combination");
    end

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t     state, state_nx;
    logic [1:0] sel_q, sel_nx;
    logic [1:0] last_q, last_nx;
    logic       en_q, en_nx;
    logic [3:0] grant_q, grant_nx;
    logic       busy_q, busy_nx;
    logic       timeout_q, timeout_nx;
    logic       found;
    logic [1:0] winner;
    logic       release_hold;
`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             hold_expired;
`endif

    // Scan last+1, last+2, last+3, last; first set request wins.
    always_comb begin
        found  = 1'b0;
        winner = last_q;
        for (int unsigned i = 1; i <= 4; i++) begin
            if (!found && bus.req[2'(last_q + 2'(i))]) begin
                found  = 1'b1;
                winner = 2'(last_q + 2'(i));
            end
        end
    end

    always_comb begin
        state_nx     = state;
        sel_nx       = sel_q;
        last_nx      = last_q;
        en_nx        = en_q;
        grant_nx     = grant_q;
        timeout_nx   = 1'b0;
        release_hold = bus.done || !bus.req[sel_q];
`ifdef ARB_TIMEOUT_EN
        cnt_nx       = cnt_q;
        hold_expired = (cnt_q == CNT_W'(MAX_HOLD - 1));
`endif
        case (state)
            IDLE: begin
                en_nx    = 1'b0;
                grant_nx = '0;
                if (found) begin
                    sel_nx   = winner;
                    last_nx  = winner;
                    en_nx    = 1'b1;
                    grant_nx = 4'b0001 << winner;
                    state_nx = BUSY;
`ifdef ARB_TIMEOUT_EN
                    cnt_nx   = '0;
`endif
                end
            end
            BUSY: begin
`ifdef ARB_TIMEOUT_EN
                if (cnt_q != CNT_W'(MAX_HOLD))
                    cnt_nx = cnt_q + CNT_W'(1);
                if (release_hold || hold_expired) begin
                    en_nx      = 1'b0;
                    grant_nx   = '0;
                    state_nx   = GAP;
                    // A normal release in the same cycle wins over the timeout.
                    timeout_nx = hold_expired && !release_hold;
                end
`else
                if (release_hold) begin
                    en_nx    = 1'b0;
                    grant_nx = '0;
                    state_nx = GAP;
                end
`endif
            end
            GAP: begin
                en_nx    = 1'b0;
                grant_nx = '0;
                state_nx = IDLE;
            end
            default: begin
                en_nx    = 1'b0;
                grant_nx = '0;
                state_nx = IDLE;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel_q     <= '0;
            last_q    <= '1;
            en_q      <= 1'b0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state     <= state_nx;
            sel_q     <= sel_nx;
            last_q    <= last_nx;
            en_q      <= en_nx;
            grant_q   <= grant_nx;
            busy_q    <= busy_nx;
            timeout_q <= timeout_nx;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_nx;
`endif
        end
    end

    assign bus.sel     = sel_q;
    assign bus.en      = en_q;
    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed self-checking bench for rr_decoder_arbiter (works with or without ARB_TIMEOUT_EN).
module tb_rr_decoder_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rr_decoder_arbiter_if bus ();

    rr_decoder_arbiter #(
        .MAX_HOLD (8),
        .CNT_W    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic e, input logic b);
        chk({tag, ".grant"}, 8'(bus.grant), 8'(g));
        chk({tag, ".sel"},   8'(bus.sel),   8'(s));
        chk({tag, ".en"},    8'(bus.en),    8'(e));
        chk({tag, ".busy"},  8'(bus.busy),  8'(b));
    endtask

    logic [3:0] rr_exp [5];
    logic [1:0] rr_sel [5];
    logic       to_en;

    initial begin
        total = 0;
        bad   = 0;
`ifdef ARB_TIMEOUT_EN
        to_en = 1'b1;
`else
        to_en = 1'b0;
`endif
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        #3;
        chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("reset.timeout", 8'(bus.timeout), 8'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Full rotation with all four requesting.
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out($sformatf("rr%0d.grant1", k), rr_exp[k], rr_sel[k], 1'b1, 1'b1);
            tick();
            chk_out($sformatf("rr%0d.grant2", k), rr_exp[k], rr_sel[k], 1'b1, 1'b1);
            bus.done = 1'b1;
            tick();
            chk_out($sformatf("rr%0d.gap", k), 4'b0000, rr_sel[k], 1'b0, 1'b1);
            bus.done = 1'b0;
            tick();
            chk_out($sformatf("rr%0d.idle", k), 4'b0000, rr_sel[k], 1'b0, 1'b0);
        end
        bus.req = 4'b0000;

        // done while idle is ignored.
        bus.done = 1'b1;
        tick();
        chk_out("idle_done", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus.done = 1'b0;

        // Single requester 2, done in third cycle.
        bus.req = 4'b0100;
        tick();
        chk_out("r2.c1", 4'b0100, 2'd2, 1'b1, 1'b1);
        tick();
        chk_out("r2.c2", 4'b0100, 2'd2, 1'b1, 1'b1);
        tick();
        chk_out("r2.c3", 4'b0100, 2'd2, 1'b1, 1'b1);
        bus.done = 1'b1;
        tick();
        chk_out("r2.gap", 4'b0000, 2'd2, 1'b0, 1'b1);
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        tick();
        chk_out("r2.idle", 4'b0000, 2'd2, 1'b0, 1'b0);

        // Requester 1 drops its request without done.
        bus.req = 4'b0010;
        tick();
        chk_out("r1.c1", 4'b0010, 2'd1, 1'b1, 1'b1);
        tick();
        chk_out("r1.c2", 4'b0010, 2'd1, 1'b1, 1'b1);
        bus.req = 4'b0000;
        tick();
        chk_out("r1.gap", 4'b0000, 2'd1, 1'b0, 1'b1);
        chk("r1.timeout", 8'(bus.timeout), 8'd0);
        tick();
        chk_out("r1.idle", 4'b0000, 2'd1, 1'b0, 1'b0);

        // Long hold on requester 0: forced release only with the timeout feature.
        bus.req = 4'b0001;
        tick();
        chk_out("hold.c1", 4'b0001, 2'd0, 1'b1, 1'b1);
        for (int c = 2; c <= 8; c++) tick();
        chk_out("hold.c8", 4'b0001, 2'd0, 1'b1, 1'b1);
        chk("hold.c8.timeout", 8'(bus.timeout), 8'd0);
        tick();
        chk("hold.c9.en", 8'(bus.en), 8'(!to_en));
        chk("hold.c9.timeout", 8'(bus.timeout), 8'(to_en));
        chk("hold.c9.busy", 8'(bus.busy), 8'd1);
        tick();
        chk("hold.c10.timeout", 8'(bus.timeout), 8'd0);
        chk("hold.c10.busy", 8'(bus.busy), 8'(!to_en));
        tick();
        chk_out("hold.c11", 4'b0001, 2'd0, 1'b1, 1'b1);
        bus.req = 4'b0000;
        tick();
        tick();
        chk_out("hold.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // done coincides with the hold limit on requester 1; pointer then moves on to 0.
        bus.req = 4'b0011;
        tick();
        chk_out("coin.c1", 4'b0010, 2'd1, 1'b1, 1'b1);
        for (int c = 2; c <= 8; c++) tick();
        chk_out("coin.c8", 4'b0010, 2'd1, 1'b1, 1'b1);
        bus.done = 1'b1;
        tick();
        chk_out("coin.gap", 4'b0000, 2'd1, 1'b0, 1'b1);
        chk("coin.timeout", 8'(bus.timeout), 8'd0);
        bus.done = 1'b0;
        tick();
        chk_out("coin.idle", 4'b0000, 2'd1, 1'b0, 1'b0);
        tick();
        chk_out("coin.next", 4'b0001, 2'd0, 1'b1, 1'b1);
        bus.req = 4'b0000;
        tick();
        tick();

        // Requester 3 granted, then asynchronous reset mid-grant.
        bus.req = 4'b1000;
        tick();
        chk_out("r3.c1", 4'b1000, 2'd3, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus.req = 4'b1001;
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("post_rst", 4'b0001, 2'd0, 1'b1, 1'b1);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        tick();
        chk_out("end.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
